channel_scan_mux: RTL and testbench
===================================

# channel_scan_mux

Parametrised, registered N:1 channel selector with a manual-select mode and an auto-scan mode. Auto-scan rotates through the channels enabled in a mask, holding each for a programmable dwell time. The block is the sequential successor of the team's fixed 2/4/8-input combinational muxes and sits between the input banks and any downstream consumer that needs a time-multiplexed, tagged sample stream.

## Interface
Parameters:
- WIDTH, 1, bits per channel
- CHANNELS, 8, number of input channels; must be ≥ 2
- DWELL, 4, cycles each channel is held in scan mode; must be ≥ 1
- SEL_W, $clog2(CHANNELS), derived; not overridden

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH]
- select  in  SEL_W  manual channel index
- mode  in  1  0 = manual, 1 = scan
- channel_mask  in  CHANNELS  scan participation; bit k set means channel k is scanned
- enable  in  1  block enable
- out  out  WIDTH  registered selected data
- out_channel  out  SEL_W  index of the channel driving out
- out_valid  out  1  out/out_channel are meaningful
- scan_wrap  out  1  one-cycle pulse when the scan pointer wraps to a lower-or-equal index

## Operation
FSM states:
- **IDLE**
  - Entered on reset or whenever enable = 0.
  - Drives out = 0, out_channel = 0, out_valid = 0.
  - Holds the scan pointer `cur` and the dwell counter `dcnt`.
- **MANUAL** (enable = 1, mode = 0)
  - Each cycle: out <= in_data[select], out_channel <= select, out_valid <= 1.
  - If select ≥ CHANNELS: out <= 0, out_valid <= 0.
- **SCAN_LOAD** (entered when mode goes 0→1, or enable goes 1 with mode = 1)
  - cur <= lowest set bit of channel_mask; dcnt <= 0; out_valid <= 0.
  - Next state is SCAN_RUN.
- **SCAN_RUN**
  - Each cycle: out <= in_data[cur], out_channel <= cur, out_valid <= 1, dcnt <= dcnt + 1.
  - When dcnt == DWELL-1: cur <= next set mask bit searching circularly from cur+1; dcnt <= 0.
  - scan_wrap <= 1 on that advance if the new index ≤ cur.
- **Transitions**
  - mode = 0 in any scan state goes to MANUAL on the next edge.
  - enable = 0 goes to IDLE from any state.

Boundary rules:
- **channel_mask == 0 in scan:**
  - out_valid <= 0, out <= 0, scan_wrap stays 0.
  - cur and dcnt hold.
  - When a bit becomes set, the block re-enters SCAN_LOAD.
- **Single mask bit set:** cur never changes; scan_wrap pulses every DWELL cycles.
- **Mask bit of cur cleared mid-dwell:**
  - On the next edge, cur advances to the next set bit and dcnt <= 0.
  - The stale channel is not output in that cycle; out_valid <= 0 for that one cycle.
- **in_data changes mid-dwell:** the change passes through the next cycle; data is not latched at the start of the dwell.
- **Reset mid-operation:** all registers return to reset values immediately (asynchronous). The first cycle after release is IDLE.

## Timing
- Reset values: out = 0, out_channel = 0, out_valid = 0, scan_wrap = 0, cur = 0, dcnt = 0, state IDLE.
- Manual latency: 1 cycle from select/in_data to out.
- Scan:
  - Entering scan costs one SCAN_LOAD cycle with out_valid = 0.
  - Each enabled channel then appears on out for exactly DWELL consecutive cycles.
  - scan_wrap is coincident with the first output cycle of the wrapped-to channel.
- Simultaneous mode toggle and dwell expiry: the mode change wins and the advance is discarded.
- There is no backpressure; the consumer must sample whenever out_valid = 1.

## Structure
- Shared package `chan_mux_pkg`:
  - state enum (IDLE, MANUAL, SCAN_LOAD, SCAN_RUN)
  - mode encodings MODE_MANUAL = 0, MODE_SCAN = 1
- Sub-module `mask_next_channel`:
  - combinational circular priority finder
  - inputs: mask, start index; outputs: next index, found flag, wrapped flag
  - instantiated twice: lowest set bit (start = 0, inclusive), and advance (start = cur+1)
- Dwell counter width: $clog2(DWELL) bits, minimum 1.

## Test plan
Configuration for all cases: CHANNELS = 8, WIDTH = 4, DWELL = 3, in_data channel k = k+1.
1. **Manual select:** enable = 1, mode = 0, select = 5 → next cycle out = 6, out_channel = 5, out_valid = 1. Then select = 9 (with a 4-bit SEL_W override) → out = 0, out_valid = 0.
2. **Scan rotation:** mode = 1, mask = 8'b1010_0100 → one invalid cycle, then channels 2, 5, 7 for 3 cycles each, back to 2, with scan_wrap high on the first cycle of channel 2's return.
3. **Mask edits:**
   - Clear bit 5 while out_channel = 5, dcnt = 1 → next cycle out_valid = 0, then channel 7 for 3 cycles.
   - mask = 0 → out_valid stays 0.
4. **Single channel:** mask = 8'b0000_1000 → out = 4 continuously; scan_wrap pulses every 3 cycles.
5. **Enable/reset:**
   - enable = 0 mid-dwell → IDLE outputs zero; re-enable → SCAN_LOAD restarts at the lowest set bit.
   - rst_n low mid-scan (asynchronous, between edges) → all outputs 0 immediately.
6. **Mode toggle at dwell expiry:** set mode = 0 on the cycle dcnt = 2 → MANUAL output next cycle; cur is not advanced.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel scan multiplexer.
//   state_t     : controller states (IDLE, MANUAL, SCAN_LOAD, SCAN_RUN)
//   MODE_MANUAL : mode input value selecting manual channel select
//   MODE_SCAN   : mode input value selecting auto-scan
package chan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MANUAL    = 2'd1,
    SCAN_LOAD = 2'd2,
    SCAN_RUN  = 2'd3
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mask_next_channel.sv
// Combinational circular priority finder over a channel mask.
//   i_mask    : channel participation mask
//   i_start   : first index to examine (0..CHANNELS); CHANNELS means "wrap to 0"
//   o_next    : first set index found searching circularly from i_start
//   o_found   : at least one mask bit is set
//   o_wrapped : the found index lies below i_start (search went past the top)
module mask_next_channel #(
  parameter int CHANNELS = 8,
  parameter int IW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_mask,
  input  logic [IW:0]         i_start,
  output logic [IW-1:0]       o_next,
  output logic                o_found,
  output logic                o_wrapped
);

  // Walk the offsets from the far end back to zero so the smallest offset
  // (the nearest set bit after i_start) is the last one to assign.
  always_comb begin
    o_next    = '0;
    o_found   = 1'b0;
    o_wrapped = 1'b0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      int idx;
      idx = int'(i_start) + j;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (i_mask[IW'(idx)]) begin
        o_next    = IW'(idx);
        o_found   = 1'b1;
        o_wrapped = (idx < int'(i_start));
      end
    end
  end

endmodule

// File: rtl/channel_scan_mux.sv
// Registered N:1 channel selector with manual select and auto-scan modes.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   in_data      : packed channels, channel k at [k*WIDTH +: WIDTH]
//   select       : manual channel index (out of range gives out_valid = 0)
//   mode         : 0 manual, 1 scan
//   channel_mask : channels taking part in the scan
//   enable       : block enable; low forces IDLE with zeroed outputs
//   out          : registered selected data
//   out_channel  : channel index driving out
//   out_valid    : out/out_channel are meaningful
//   scan_wrap    : pulse on the first output cycle after the scan pointer
//                  moves to a lower-or-equal index
module channel_scan_mux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          select,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       channel_mask,
  input  logic                      enable,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_channel,
  output logic                      out_valid,
  output logic                      scan_wrap
);
  import chan_mux_pkg::*;

  localparam int CUR_W  = $clog2(CHANNELS);
  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL - 1);

  state_t             r_state;
  logic [CUR_W-1:0]   r_cur;
  logic [DCNT_W-1:0]  r_dcnt;
  logic               r_wrap_pend;
  logic [WIDTH-1:0]   r_out;
  logic [SEL_W-1:0]   r_out_channel;
  logic               r_out_valid;
  logic               r_scan_wrap;

  logic [WIDTH-1:0]   w_ch [CHANNELS];
  logic               w_sel_ok;
  logic [CUR_W-1:0]   w_sel_idx;
  logic [CUR_W-1:0]   w_lo_idx;
  logic               w_lo_found;
  logic               w_lo_wrapped;
  logic [CUR_W:0]     w_adv_start;
  logic [CUR_W-1:0]   w_adv_idx;
  logic               w_adv_found;
  logic               w_adv_wrapped;
  logic [1:0]         w_unused_flags;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign w_ch[k] = in_data[k*WIDTH +: WIDTH];
  end

  assign w_sel_ok    = (int'(select) < CHANNELS);
  assign w_sel_idx   = CUR_W'(select);
  assign w_adv_start = {1'b0, r_cur} + (CUR_W+1)'(1);

  // Lowest enabled channel, used when a scan is (re)started.
  mask_next_channel #(.CHANNELS(CHANNELS), .IW(CUR_W)) u_lowest (
    .i_mask    (channel_mask),
    .i_start   ('0),
    .o_next    (w_lo_idx),
    .o_found   (w_lo_found),
    .o_wrapped (w_lo_wrapped)
  );

  // Next enabled channel after cur; wrapped means the new index is <= cur.
  mask_next_channel #(.CHANNELS(CHANNELS), .IW(CUR_W)) u_advance (
    .i_mask    (channel_mask),
    .i_start   (w_adv_start),
    .o_next    (w_adv_idx),
    .o_found   (w_adv_found),
    .o_wrapped (w_adv_wrapped)
  );

  // A non-empty mask always yields a hit, so these flags carry no new information.
  assign w_unused_flags = {w_lo_wrapped, w_adv_found};

  // An empty scan mask parks the block in IDLE (cur/dcnt held) so that the
  // first non-empty mask goes through a fresh SCAN_LOAD. A wrap is detected
  // when cur moves, but reported one edge later, when the wrapped-to channel
  // first reaches out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cur         <= '0;
      r_dcnt        <= '0;
      r_wrap_pend   <= 1'b0;
      r_out         <= '0;
      r_out_channel <= '0;
      r_out_valid   <= 1'b0;
      r_scan_wrap   <= 1'b0;
    end else begin
      r_scan_wrap <= 1'b0;
      if (!enable) begin
        r_state       <= IDLE;
        r_out         <= '0;
        r_out_channel <= '0;
        r_out_valid   <= 1'b0;
        r_wrap_pend   <= 1'b0;
      end else if (mode == MODE_MANUAL) begin
        r_state       <= MANUAL;
        r_out_channel <= select;
        r_wrap_pend   <= 1'b0;
        if (w_sel_ok) begin
          r_out       <= w_ch[w_sel_idx];
          r_out_valid <= 1'b1;
        end else begin
          r_out       <= '0;
          r_out_valid <= 1'b0;
        end
      end else if (!w_lo_found) begin
        r_state       <= IDLE;
        r_out         <= '0;
        r_out_channel <= '0;
        r_out_valid   <= 1'b0;
        r_wrap_pend   <= 1'b0;
      end else if (r_state == IDLE || r_state == MANUAL) begin
        r_state       <= SCAN_LOAD;
        r_cur         <= w_lo_idx;
        r_dcnt        <= '0;
        r_out         <= '0;
        r_out_channel <= '0;
        r_out_valid   <= 1'b0;
        r_wrap_pend   <= 1'b0;
      end else if (!channel_mask[r_cur]) begin
        // Current channel dropped out of the mask: skip it without output.
        r_state       <= SCAN_RUN;
        r_cur         <= w_adv_idx;
        r_dcnt        <= '0;
        r_out         <= '0;
        r_out_channel <= '0;
        r_out_valid   <= 1'b0;
        r_wrap_pend   <= w_adv_wrapped;
      end else begin
        r_state       <= SCAN_RUN;
        r_out         <= w_ch[r_cur];
        r_out_channel <= SEL_W'(r_cur);
        r_out_valid   <= 1'b1;
        r_scan_wrap   <= r_wrap_pend;
        r_wrap_pend   <= 1'b0;
        if (r_dcnt == DWELL_LAST) begin
          r_cur       <= w_adv_idx;
          r_dcnt      <= '0;
          r_wrap_pend <= w_adv_wrapped;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
    end
  end

  assign out         = r_out;
  assign out_channel = r_out_channel;
  assign out_valid   = r_out_valid;
  assign scan_wrap   = r_scan_wrap;

endmodule

// File: tb/tb_channel_scan_mux.sv
// Self-checking bench for channel_scan_mux (CHANNELS=8, WIDTH=4, DWELL=3,
// SEL_W=4 so out-of-range manual selects can be driven).
module tb_channel_scan_mux;

  localparam int CH = 8;
  localparam int W  = 4;
  localparam int DW = 3;
  localparam int SW = 4;

  logic            clk;
  logic            rst_n;
  logic [CH*W-1:0] in_data;
  logic [SW-1:0]   select;
  logic            mode;
  logic [CH-1:0]   channel_mask;
  logic            enable;
  logic [W-1:0]    out;
  logic [SW-1:0]   out_channel;
  logic            out_valid;
  logic            scan_wrap;

  channel_scan_mux #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW), .SEL_W(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .select       (select),
    .mode         (mode),
    .channel_mask (channel_mask),
    .enable       (enable),
    .out          (out),
    .out_channel  (out_channel),
    .out_valid    (out_valid),
    .scan_wrap    (scan_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 = off/parked (next scan edge reloads), 1 = manual, 2 = scanning.
  // m_left counts the outputs still owed to the current channel.
  int       m_phase = 0;
  int       m_cur = 0;
  int       m_left = DW;
  bit       m_wrap_due = 1'b0;
  logic [3:0] e_out = '0;
  logic [3:0] e_ch = '0;
  bit       e_valid = 1'b0;
  bit       e_wrap = 1'b0;
  bit       e_chk_out = 1'b1;
  bit       e_chk_ch = 1'b1;

  function automatic logic [3:0] chan_data(input logic [31:0] d, input int k);
    return d[k*4 +: 4];
  endfunction

  function automatic int lowest(input logic [7:0] m);
    for (int k = 0; k < CH; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic int next_after(input int c, input logic [7:0] m);
    for (int s = 1; s <= CH; s++) if (m[(c + s) % CH]) return (c + s) % CH;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cur = 0; m_left = DW; m_wrap_due = 1'b0;
      e_out = '0; e_ch = '0; e_valid = 1'b0; e_wrap = 1'b0;
      e_chk_out = 1'b1; e_chk_ch = 1'b1;
    end else begin
      int nxt;
      e_out = '0; e_ch = '0; e_valid = 1'b0; e_wrap = 1'b0;
      e_chk_out = 1'b0; e_chk_ch = 1'b0;
      if (!enable) begin
        m_phase = 0; e_chk_out = 1'b1; e_chk_ch = 1'b1;
      end else if (!mode) begin
        m_phase = 1; e_ch = select; e_chk_out = 1'b1; e_chk_ch = 1'b1;
        if (int'(select) < CH) begin
          e_out = chan_data(in_data, int'(select));
          e_valid = 1'b1;
        end
      end else if (channel_mask == '0) begin
        m_phase = 0; e_chk_out = 1'b1;
      end else if (m_phase != 2) begin
        m_phase = 2; m_cur = lowest(channel_mask); m_left = DW; m_wrap_due = 1'b0;
      end else if (!channel_mask[m_cur]) begin
        nxt = next_after(m_cur, channel_mask);
        m_wrap_due = (nxt <= m_cur); m_cur = nxt; m_left = DW;
      end else begin
        e_out = chan_data(in_data, m_cur); e_ch = 4'(m_cur); e_valid = 1'b1;
        e_chk_out = 1'b1; e_chk_ch = 1'b1;
        e_wrap = m_wrap_due; m_wrap_due = 1'b0;
        m_left--;
        if (m_left == 0) begin
          nxt = next_after(m_cur, channel_mask);
          m_wrap_due = (nxt <= m_cur); m_cur = nxt; m_left = DW;
        end
      end
    end
  end

  // ---------------- continuous compare against the model ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("mdl_valid", 32'(out_valid), 32'(e_valid));
      chk("mdl_wrap", 32'(scan_wrap), 32'(e_wrap));
      if (e_chk_out) chk("mdl_out", 32'(out), 32'(e_out));
      if (e_chk_ch) chk("mdl_chan", 32'(out_channel), 32'(e_ch));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out"}, 32'(out), 0);
    chk({nm, "_chan"}, 32'(out_channel), 0);
    chk({nm, "_valid"}, 32'(out_valid), 0);
    chk({nm, "_wrap"}, 32'(scan_wrap), 0);
  endtask

  int seq2 [11] = '{-1, 2, 2, 2, 5, 5, 5, 7, 7, 7, 2};

  initial begin
    rst_n = 1'b1; enable = 1'b0; mode = 1'b0; select = '0; channel_mask = '0;
    in_data = 32'h8765_4321;
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;

    // Manual select
    enable = 1'b1; mode = 1'b0; select = 4'd5;
    step();
    chk("man_out", 32'(out), 6);
    chk("man_chan", 32'(out_channel), 5);
    chk("man_valid", 32'(out_valid), 1);
    select = 4'd9;
    step();
    chk("man_oor_out", 32'(out), 0);
    chk("man_oor_valid", 32'(out_valid), 0);

    // Scan rotation over channels 2, 5, 7
    channel_mask = 8'b1010_0100; mode = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      chk("rot_valid", 32'(out_valid), (seq2[i] >= 0) ? 1 : 0);
      if (seq2[i] >= 0) begin
        chk("rot_chan", 32'(out_channel), seq2[i]);
        chk("rot_out", 32'(out), seq2[i] + 1);
      end
      chk("rot_wrap", 32'(scan_wrap), (i == 10) ? 1 : 0);
    end

    // Drop channel 5 during its first output cycle
    repeat (3) step();
    chk("edit_chan5", 32'(out_channel), 5);
    channel_mask = 8'b1000_0100;
    step();
    chk("edit_skip_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("edit_chan7", 32'(out_channel), 7);
      chk("edit_out7", 32'(out), 8);
    end
    step();
    chk("edit_back2", 32'(out_channel), 2);
    chk("edit_wrap", 32'(scan_wrap), 1);

    // Empty mask
    channel_mask = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("empty_valid", 32'(out_valid), 0);
      chk("empty_out", 32'(out), 0);
    end

    // Single channel
    channel_mask = 8'b0000_1000;
    step();
    chk("single_load_valid", 32'(out_valid), 0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("single_out", 32'(out), 4);
      chk("single_valid", 32'(out_valid), 1);
      chk("single_wrap", 32'(scan_wrap), (i == 3 || i == 6) ? 1 : 0);
    end

    // Enable drop and restart
    enable = 1'b0;
    step();
    chk_zero("disable");
    channel_mask = 8'b0100_1000; enable = 1'b1;
    step();
    chk("reen_valid", 32'(out_valid), 0);
    step();
    chk("reen_chan", 32'(out_channel), 3);
    chk("reen_out", 32'(out), 4);

    // Asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();

    // Mode drop on the dwell-expiry cycle
    mode = 1'b0; select = 4'd0; channel_mask = 8'b1010_0100;
    step();
    mode = 1'b1;
    repeat (3) step();
    chk("tog_pre_chan", 32'(out_channel), 2);
    mode = 1'b0; select = 4'd1;
    step();
    chk("tog_man_out", 32'(out), 2);
    chk("tog_man_chan", 32'(out_channel), 1);
    chk("tog_man_valid", 32'(out_valid), 1);
    mode = 1'b1;
    step();
    chk("tog_load_valid", 32'(out_valid), 0);
    step();
    chk("tog_rescan_chan", 32'(out_channel), 2);
    chk("tog_rescan_wrap", 32'(scan_wrap), 0);

    // Randomized operation against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      in_data = $urandom;
      select = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 99) >= 4);
      if ($urandom_range(0, 99) < 4) mode = ~mode;
      if ($urandom_range(0, 99) < 4) begin
        case ($urandom_range(0, 3))
          0:       channel_mask = '0;
          1:       channel_mask = 8'(1 << $urandom_range(0, 7));
          default: channel_mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("rnd_rst");
        step();
        rst_n = 1'b1;
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
